key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_multi.sv | 110 +++++++++++
 tb/tb_key_debounce_multi.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release pulses and an optional long-press
// detector, enabled by defining KEY_LONG_PRESS_EN.

module key_debounce_lane #(
  parameter int CNT_MAX    = 1_000_000,
  parameter int LONG_MAX   = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int            CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);
  localparam logic          IDLE    = ACTIVE_LOW;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          raw;

  // After normalisation, 1 always means pressed.
  assign raw = sync[1] ^ IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= {2{IDLE}};
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync        <= {sync[0], key_in};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (raw == key_state) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        key_state   <= raw;
        cnt         <= '0;
        key_press   <= raw;
        key_release <= ~raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int            LW       = $clog2(LONG_MAX);
  localparam logic [LW-1:0] LONG_TOP = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_MAX - 2);

  logic [LW-1:0] lcnt;

  // Saturating at the top value gives one pulse per press; a release re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt     <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (!key_state) begin
        lcnt <= '0;
      end else if (lcnt != LONG_TOP) begin
        lcnt     <= lcnt + 1'b1;
        key_long <= (lcnt == LONG_PRE);
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

module key_debounce_multi #(
  parameter int KEY_W      = 4,
  parameter int CNT_MAX    = 1_000_000,
  parameter int LONG_MAX   = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);
  for (genvar g = 0; g < KEY_W; g++) begin : g_lane
    key_debounce_lane #(
      .CNT_MAX   (CNT_MAX),
      .LONG_MAX  (LONG_MAX),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[g]),
      .key_state  (key_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: latency, bounce rejection, release,
// simultaneous channels, long press (when KEY_LONG_PRESS_EN is defined), reset.

module tb_key_debounce_multi;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_state, key_press, key_release, key_long;

  int n_assert = 0;
  int n_fail   = 0;

  key_debounce_multi #(
    .KEY_W(2), .CNT_MAX(10), .LONG_MAX(40), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] pr,
                         input logic [1:0] rl);
    chk({tag, ".state"},   key_state,   st);
    chk({tag, ".press"},   key_press,   pr);
    chk({tag, ".release"}, key_release, rl);
  endtask

  function automatic logic [1:0] long_exp(input logic [1:0] v);
`ifdef KEY_LONG_PRESS_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  initial begin
    // 1: reset state and basic press latency on ch0
    rst_n  = 1'b0;
    key_in = 2'b11;
    tick(3);
    chk_all("reset", 2'b00, 2'b00, 2'b00);
    chk("reset.long", key_long, 2'b00);
    rst_n = 1'b1;
    tick(2);
    key_in = 2'b10;          // next edge is N
    tick(11);                // after edge N+10
    chk_all("s1.n10", 2'b00, 2'b00, 2'b00);
    tick();                  // after edge N+11
    chk_all("s1.n11", 2'b01, 2'b01, 2'b00);
    tick();
    chk_all("s1.n12", 2'b01, 2'b00, 2'b00);

    // 2: bounce on ch1 (9 low, 1 high, 9 low) is rejected
    key_in = 2'b00;
    for (int i = 0; i < 9; i++) begin tick(); chk("s2.b1", key_press, 2'b00); end
    key_in = 2'b10;
    tick();
    key_in = 2'b00;
    for (int i = 0; i < 9; i++) begin tick(); chk("s2.b2", key_press, 2'b00); end
    key_in = 2'b10;
    for (int i = 0; i < 14; i++) begin tick(); chk("s2.idle", key_state, 2'b01); end
    key_in = 2'b00;
    tick(11);
    chk_all("s2.n10", 2'b01, 2'b00, 2'b00);
    tick();
    chk_all("s2.n11", 2'b11, 2'b10, 2'b00);

    // 3: release ch0
    key_in = 2'b01;
    tick(11);
    chk_all("s3.n10", 2'b11, 2'b00, 2'b00);
    tick();
    chk_all("s3.n11", 2'b10, 2'b00, 2'b01);
    tick();
    chk_all("s3.n12", 2'b10, 2'b00, 2'b00);

    // 4: release ch1, then press both together, long-press window, release ch1
    key_in = 2'b11;
    tick(12);
    chk_all("s4.rel1", 2'b00, 2'b00, 2'b10);
    key_in = 2'b00;
    tick(11);
    chk_all("s4.n10", 2'b00, 2'b00, 2'b00);
    tick();                  // edge E: key_state rises
    chk_all("s4.both", 2'b11, 2'b11, 2'b00);
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk($sformatf("s5.long%0d", i), key_long, long_exp((i == 39) ? 2'b11 : 2'b00));
    end
    key_in = 2'b10;
    tick(11);
    chk_all("s4.r10", 2'b11, 2'b00, 2'b00);
    tick();
    chk_all("s4.r11", 2'b01, 2'b00, 2'b10);

    // 5: release and re-press ch0 re-arms the long detector
    key_in = 2'b11;
    tick(12);
    chk_all("s5.rel0", 2'b00, 2'b00, 2'b01);
    key_in = 2'b10;
    tick(12);
    chk_all("s5.rep0", 2'b01, 2'b01, 2'b00);
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk($sformatf("s5.relong%0d", i), key_long, long_exp((i == 39) ? 2'b01 : 2'b00));
    end

    // 6: asynchronous reset mid-count, key still held afterwards
    key_in = 2'b00;          // ch1 starts counting toward a press
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk_all("s6.async", 2'b00, 2'b00, 2'b00);
    chk("s6.async.long", key_long, 2'b00);
    tick();
    rst_n = 1'b1;            // next edge is the first sampled edge
    tick(11);
    chk_all("s6.n10", 2'b00, 2'b00, 2'b00);
    tick();
    chk_all("s6.n11", 2'b11, 2'b11, 2'b00);
    tick();
    chk_all("s6.n12", 2'b11, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
